reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 15 +
 rtl/reg_scoreboard_lat_counter.sv | 32 +++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared processor constants for the register scoreboard and register file.
// Also holds the writeback payload type driven toward the register file.
package reg_scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS = 8;
  localparam int unsigned SB_SEL_W    = 3;
  localparam int unsigned SB_LAT_W    = 2;
  localparam int unsigned SB_SEL_SPAN = 2 ** SB_SEL_W;

  typedef struct packed {
    logic                en;
    logic [SB_SEL_W-1:0] sel;
  } wb_t;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_lat_counter.sv
// Per-register issue-latency down-counter: clear beats load, load beats decrement.
// The counter reaching one marks the cycle its register-file write happens.
module reg_lat_counter #(
  parameter int unsigned LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_is_one,
  output logic             o_is_zero
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_lat;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_one  = (r_cnt == LAT_W'(1));
  assign o_is_zero = (r_cnt == '0);

endmodule : reg_lat_counter

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register, stalls RAW/WAW hazards
// and single-write-port conflicts, and drives the register-file write select.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned LAT_W    = SB_LAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issueEn,
  input  logic [SB_SEL_W-1:0] issueDst,
  input  logic [LAT_W-1:0]    issueLat,
  input  logic                issueSrc1En,
  input  logic                issueSrc2En,
  input  logic [SB_SEL_W-1:0] issueSrc1,
  input  logic [SB_SEL_W-1:0] issueSrc2,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic                wbEn,
  output logic [SB_SEL_W-1:0] wbSel,
  output logic                err
);

  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_is_one;
  logic [NUM_REGS-1:0] w_is_zero;
  logic [NUM_REGS-1:0] w_load;
  logic [SB_SEL_SPAN-1:0] w_busy_span;
  logic [LAT_W:0]      w_lat_p1;
  logic                w_port_conflict;
  logic                w_accept;
  wb_t                 w_wb;

  assign busy        = ~w_is_zero;
  assign w_busy_span = SB_SEL_SPAN'(busy);
  assign w_lat_p1    = {1'b0, issueLat} + (LAT_W + 1)'(1);

  // A new write of latency L collides with any write whose counter is L+1.
  always_comb begin
    w_port_conflict = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if ({1'b0, w_cnt[r]} == w_lat_p1) begin
        w_port_conflict = 1'b1;
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    if (issueEn) begin
      stall = (issueSrc1En && w_busy_span[issueSrc1])
           || (issueSrc2En && w_busy_span[issueSrc2])
           || w_busy_span[issueDst]
           || w_port_conflict;
    end
  end

  assign err = (issueEn && (issueLat == '0))
            || $isunknown({issueEn, issueDst, issueLat, issueSrc1En, issueSrc1,
                           issueSrc2En, issueSrc2, flush});

  assign w_accept = issueEn && !stall && !flush && !err;

  always_comb begin
    w_load = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_load[r] = w_accept && (issueDst == SB_SEL_W'(r));
    end
  end

  // Conflict stalls keep at most one counter at one, so a plain scan suffices.
  always_comb begin
    w_wb = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (w_is_one[r]) begin
        w_wb.en  = 1'b1;
        w_wb.sel = SB_SEL_W'(r);
      end
    end
  end

  assign wbEn  = w_wb.en;
  assign wbSel = w_wb.sel;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    reg_lat_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (flush),
      .i_load   (w_load[g]),
      .i_lat    (issueLat),
      .o_cnt    (w_cnt[g]),
      .o_is_one (w_is_one[g]),
      .o_is_zero(w_is_zero[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(w_is_one));
    end
  end

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic, all
// checked against a model of pending writes kept as absolute due cycles.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst;
  logic       issueEn;
  logic [2:0] issueDst;
  logic [1:0] issueLat;
  logic       issueSrc1En;
  logic       issueSrc2En;
  logic [2:0] issueSrc1;
  logic [2:0] issueSrc2;
  logic       flush;
  logic       stall;
  logic [7:0] busy;
  logic       wbEn;
  logic [2:0] wbSel;
  logic       err;

  int n_tests;
  int n_fail;

  // Model: cycle number in which each register's pending write lands.
  localparam int NONE = -100;
  int now;
  int due [8];

  reg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .issueEn    (issueEn),
    .issueDst   (issueDst),
    .issueLat   (issueLat),
    .issueSrc1En(issueSrc1En),
    .issueSrc2En(issueSrc2En),
    .issueSrc1  (issueSrc1),
    .issueSrc2  (issueSrc2),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .wbEn       (wbEn),
    .wbSel      (wbSel),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    b = '0;
    for (int r = 0; r < 8; r++) b[r] = (due[r] >= now);
    return b;
  endfunction

  function automatic logic m_wb_en();
    logic e;
    e = 1'b0;
    for (int r = 0; r < 8; r++) if (due[r] == now) e = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] m_wb_sel();
    logic [2:0] s;
    s = '0;
    for (int r = 0; r < 8; r++) if (due[r] == now) s = 3'(r);
    return s;
  endfunction

  function automatic logic m_stall();
    logic s;
    logic [7:0] b;
    b = m_busy();
    s = 1'b0;
    if (issueEn) begin
      if (issueSrc1En && b[issueSrc1]) s = 1'b1;
      if (issueSrc2En && b[issueSrc2]) s = 1'b1;
      if (b[issueDst]) s = 1'b1;
      for (int r = 0; r < 8; r++) if (due[r] == now + int'(issueLat)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic m_err();
    return issueEn && (issueLat == 2'd0);
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 8; r++) due[r] = NONE;
  endtask

  // Advance one clock, applying the same edge to the model.
  task automatic tick();
    logic acc;
    int   t;
    acc = issueEn && !m_stall() && !flush && !m_err();
    t   = now;
    @(posedge clk);
    if (rst || flush) m_clear();
    else if (acc) due[issueDst] = t + int'(issueLat);
    now++;
    #1;
  endtask

  task automatic idle();
    issueEn = 0; issueDst = 0; issueLat = 0;
    issueSrc1En = 0; issueSrc1 = 0; issueSrc2En = 0; issueSrc2 = 0;
    #1;
  endtask

  task automatic set_issue(input int dst, input int lat, input int s1en, input int s1);
    issueEn = 1; issueDst = 3'(dst); issueLat = 2'(lat);
    issueSrc1En = 1'(s1en); issueSrc1 = 3'(s1); issueSrc2En = 0; issueSrc2 = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0;
    set_issue(2, 3, 0, 0);
    tick();
    tick();
    rst = 0;
    idle();
    n_tests++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy got=%h exp=00", busy); end
    n_tests++; if (wbEn !== 1'b0) begin n_fail++; $display("FAIL reset_wbEn got=%b exp=0", wbEn); end
    n_tests++; if (wbSel !== 3'd0) begin n_fail++; $display("FAIL reset_wbSel got=%0d exp=0", wbSel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_basic();
    set_issue(3, 2, 0, 0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall got=%b exp=0", stall); end
    tick();
    idle();
    n_tests++; if (busy !== 8'h08) begin n_fail++; $display("FAIL basic_busy_c2 got=%h exp=08", busy); end
    n_tests++; if (wbEn !== 1'b0) begin n_fail++; $display("FAIL basic_wbEn_c2 got=%b exp=0", wbEn); end
    tick();
    n_tests++; if (busy !== 8'h08) begin n_fail++; $display("FAIL basic_busy_c3 got=%h exp=08", busy); end
    n_tests++; if (wbEn !== 1'b1 || wbSel !== 3'd3) begin n_fail++; $display("FAIL basic_wb_c3 got=%b/%0d exp=1/3", wbEn, wbSel); end
    tick();
    n_tests++; if (busy !== 8'h00 || wbEn !== 1'b0) begin n_fail++; $display("FAIL basic_c4 busy=%h wbEn=%b exp=00/0", busy, wbEn); end
  endtask

  task automatic test_raw();
    int stalls;
    bit accepted;
    stalls = 0; accepted = 0;
    set_issue(5, 3, 0, 0);
    tick();
    set_issue(0, 1, 1, 5);
    for (int i = 0; i < 10 && !accepted; i++) begin
      n_tests++; if (stall !== m_stall()) begin n_fail++; $display("FAIL raw_stall cyc=%0d got=%b exp=%b", i, stall, m_stall()); end
      if (stall === 1'b0) accepted = 1;
      else stalls++;
      tick();
    end
    idle();
    n_tests++; if (!accepted || stalls != 3) begin n_fail++; $display("FAIL raw_accept accepted=%0d stalls=%0d exp=1/3", accepted, stalls); end
    n_tests++; if (busy !== 8'h01 || wbEn !== 1'b1 || wbSel !== 3'd0) begin n_fail++; $display("FAIL raw_dep busy=%h wb=%b/%0d exp=01 1/0", busy, wbEn, wbSel); end
    tick();
  endtask

  task automatic test_port_conflict();
    set_issue(1, 3, 0, 0);
    tick();
    set_issue(2, 2, 0, 0);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL port_stall_lat2 got=%b exp=1", stall); end
    set_issue(2, 1, 0, 0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL port_stall_lat1 got=%b exp=0", stall); end
    tick();
    idle();
    n_tests++; if (wbEn !== 1'b1 || wbSel !== 3'd2) begin n_fail++; $display("FAIL port_wb_first got=%b/%0d exp=1/2", wbEn, wbSel); end
    tick();
    n_tests++; if (wbEn !== 1'b1 || wbSel !== 3'd1) begin n_fail++; $display("FAIL port_wb_second got=%b/%0d exp=1/1", wbEn, wbSel); end
    tick();
    n_tests++; if (wbEn !== 1'b0 || busy !== 8'h00) begin n_fail++; $display("FAIL port_done wbEn=%b busy=%h exp=0/00", wbEn, busy); end
  endtask

  task automatic test_flush();
    set_issue(4, 3, 0, 0);
    tick();
    set_issue(6, 1, 0, 0);
    flush = 1; #1;
    n_tests++; if (wbEn !== 1'b0) begin n_fail++; $display("FAIL flush_wb_same got=%b exp=0", wbEn); end
    tick();
    flush = 0;
    idle();
    n_tests++; if (busy !== 8'h00) begin n_fail++; $display("FAIL flush_busy got=%h exp=00", busy); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (wbEn !== 1'b0) begin n_fail++; $display("FAIL flush_no_wb cyc=%0d got=%b exp=0", i, wbEn); end
      tick();
    end
  endtask

  task automatic test_illegal();
    set_issue(7, 0, 0, 0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b exp=1", err); end
    tick();
    idle();
    n_tests++; if (busy !== 8'h00 || wbEn !== 1'b0) begin n_fail++; $display("FAIL illegal_nochange busy=%h wbEn=%b exp=00/0", busy, wbEn); end
    set_issue(0, 3, 0, 0);
    tick();
    set_issue(1, 3, 0, 0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_fill1 stall=%b exp=0", stall); end
    tick();
    set_issue(2, 3, 0, 0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_fill2 stall=%b exp=0", stall); end
    tick();
    idle();
    rst = 1; #1;
    n_tests++; if (busy !== 8'h07) begin n_fail++; $display("FAIL rst_inflight busy=%h exp=07", busy); end
    tick();
    rst = 0; #1;
    n_tests++; if (busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy got=%h exp=00", busy); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (wbEn !== 1'b0) begin n_fail++; $display("FAIL rst_no_wb cyc=%0d got=%b exp=0", i, wbEn); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      issueEn     = ($urandom_range(0, 9) < 7);
      issueDst    = 3'($urandom_range(0, 7));
      issueLat    = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      issueSrc1En = 1'($urandom_range(0, 1));
      issueSrc1   = 3'($urandom_range(0, 7));
      issueSrc2En = 1'($urandom_range(0, 1));
      issueSrc2   = 3'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      #1;
      n_tests++; if (stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, m_stall()); end
      n_tests++; if (err !== m_err()) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, err, m_err()); end
      n_tests++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", i, busy, m_busy()); end
      n_tests++; if (wbEn !== m_wb_en() || wbSel !== m_wb_sel()) begin n_fail++; $display("FAIL rnd_wb cyc=%0d got=%b/%0d exp=%b/%0d", i, wbEn, wbSel, m_wb_en(), m_wb_sel()); end
      tick();
    end
    rst = 0; flush = 0;
    idle();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; now = 0;
    m_clear();
    rst = 1; flush = 0;
    idle();
    test_reset();
    test_basic();
    test_raw();
    test_port_conflict();
    test_flush();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_scoreboard
